// File: rtl/prga_stage.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : prga_stage                                                     |
// | Brief    : ARC4 keystream stage: swaps S, XORs CT-RAM into PT-RAM and    |
// |            reports whether every plaintext byte is printable ASCII.       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module prga_stage #(
  parameter bit         CHECK_ASCII = 1'b1,
  parameter logic [7:0] ASCII_LO    = 8'h20,
  parameter logic [7:0] ASCII_HI    = 8'h7E
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic       pt_ok,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_LEN_RD  = 4'd1;
  localparam logic [3:0] ST_LEN_CAP = 4'd2;
  localparam logic [3:0] ST_SI_RD   = 4'd3;
  localparam logic [3:0] ST_SI_CAP  = 4'd4;
  localparam logic [3:0] ST_SJ_CAP  = 4'd5;
  localparam logic [3:0] ST_WR_J    = 4'd6;
  localparam logic [3:0] ST_PAD_RD  = 4'd7;
  localparam logic [3:0] ST_PAD_CAP = 4'd8;
  localparam logic [3:0] ST_DONE    = 4'd9;

  logic [3:0] r_state;
  logic [3:0] w_next_state;

  logic [7:0] r_i;
  logic [7:0] r_j;
  logic [7:0] r_k;
  logic [7:0] r_len;
  logic [7:0] r_si;
  logic [7:0] r_sj;
  logic       r_pt_ok;

  logic [7:0] w_i_next;
  logic [7:0] w_j_next;
  logic [7:0] w_pad_addr;
  logic [7:0] w_pt_byte;
  logic       w_printable;
  logic       w_abort;
  logic       w_last;

  assign w_i_next    = r_i + 8'd1;
  assign w_j_next    = r_j + s_rddata;
  assign w_pad_addr  = r_si + r_sj;
  assign w_pt_byte   = s_rddata ^ ct_rddata;
  assign w_printable = (w_pt_byte >= ASCII_LO) && (w_pt_byte <= ASCII_HI);
  assign w_abort     = CHECK_ASCII && !w_printable;
  assign w_last      = (r_k == r_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (en) w_next_state = ST_LEN_RD;
      ST_LEN_RD:  w_next_state = ST_LEN_CAP;
      ST_LEN_CAP: w_next_state = (ct_rddata == 8'd0) ? ST_DONE : ST_SI_RD;
      ST_SI_RD:   w_next_state = ST_SI_CAP;
      ST_SI_CAP:  w_next_state = ST_SJ_CAP;
      ST_SJ_CAP:  w_next_state = ST_WR_J;
      ST_WR_J:    w_next_state = ST_PAD_RD;
      ST_PAD_RD:  w_next_state = ST_PAD_CAP;
      ST_PAD_CAP: w_next_state = (w_abort || w_last) ? ST_DONE : ST_SI_RD;
      ST_DONE:    w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // A non-printable byte always clears pt_ok; only CHECK_ASCII turns it into an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i     <= 8'd0;
      r_j     <= 8'd0;
      r_k     <= 8'd0;
      r_len   <= 8'd0;
      r_si    <= 8'd0;
      r_sj    <= 8'd0;
      r_pt_ok <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            r_pt_ok <= 1'b1;
            r_i     <= 8'd0;
            r_j     <= 8'd0;
          end
        end
        ST_LEN_CAP: begin
          r_len <= ct_rddata;
          r_k   <= 8'd1;
        end
        ST_SI_RD: begin
          r_i <= w_i_next;
        end
        ST_SI_CAP: begin
          r_si <= s_rddata;
          r_j  <= w_j_next;
        end
        ST_SJ_CAP: begin
          r_sj <= s_rddata;
        end
        ST_PAD_CAP: begin
          if (!w_printable) r_pt_ok <= 1'b0;
          if (!w_abort && !w_last) r_k <= r_k + 8'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // ct_addr stays on k across the whole byte so ct_rddata is ready in PAD_CAP.
  always_comb begin
    s_addr    = 8'd0;
    s_wrdata  = 8'd0;
    s_wren    = 1'b0;
    ct_addr   = 8'd0;
    pt_addr   = 8'd0;
    pt_wrdata = 8'd0;
    pt_wren   = 1'b0;
    case (r_state)
      ST_LEN_CAP: begin
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
      end
      ST_SI_RD: begin
        s_addr  = w_i_next;
        ct_addr = r_k;
      end
      ST_SI_CAP: begin
        s_addr  = w_j_next;
        ct_addr = r_k;
      end
      ST_SJ_CAP: begin
        s_addr   = r_i;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
        ct_addr  = r_k;
      end
      ST_WR_J: begin
        s_addr   = r_j;
        s_wrdata = r_si;
        s_wren   = 1'b1;
        ct_addr  = r_k;
      end
      ST_PAD_RD: begin
        s_addr  = w_pad_addr;
        ct_addr = r_k;
      end
      ST_PAD_CAP: begin
        ct_addr   = r_k;
        pt_addr   = r_k;
        pt_wrdata = w_pt_byte;
        pt_wren   = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign rdy   = (r_state == ST_IDLE);
  assign pt_ok = r_pt_ok;

endmodule
`default_nettype wire

// File: tb/tb_prga_stage.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_prga_stage                                                  |
// | Brief    : Two prga_stage instances (abort on / abort off) against an    |
// |            RC4 reference model with RAM models and random messages.      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_prga_stage;

  localparam logic [7:0] FILL = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en        [2];
  logic       rdy       [2];
  logic       pt_ok     [2];
  logic [7:0] s_addr    [2];
  logic [7:0] s_rddata  [2];
  logic [7:0] s_wrdata  [2];
  logic       s_wren    [2];
  logic [7:0] ct_addr   [2];
  logic [7:0] ct_rddata [2];
  logic [7:0] pt_addr   [2];
  logic [7:0] pt_wrdata [2];
  logic       pt_wren   [2];

  always #5 clk = ~clk;

  prga_stage #(.CHECK_ASCII(1'b1), .ASCII_LO(8'h20), .ASCII_HI(8'h7E)) u_dut_chk (
    .clk(clk), .rst_n(rst_n), .en(en[0]), .rdy(rdy[0]), .pt_ok(pt_ok[0]),
    .s_addr(s_addr[0]), .s_rddata(s_rddata[0]), .s_wrdata(s_wrdata[0]), .s_wren(s_wren[0]),
    .ct_addr(ct_addr[0]), .ct_rddata(ct_rddata[0]),
    .pt_addr(pt_addr[0]), .pt_wrdata(pt_wrdata[0]), .pt_wren(pt_wren[0])
  );

  prga_stage #(.CHECK_ASCII(1'b0), .ASCII_LO(8'h20), .ASCII_HI(8'h7E)) u_dut_all (
    .clk(clk), .rst_n(rst_n), .en(en[1]), .rdy(rdy[1]), .pt_ok(pt_ok[1]),
    .s_addr(s_addr[1]), .s_rddata(s_rddata[1]), .s_wrdata(s_wrdata[1]), .s_wren(s_wren[1]),
    .ct_addr(ct_addr[1]), .ct_rddata(ct_rddata[1]),
    .pt_addr(pt_addr[1]), .pt_wrdata(pt_wrdata[1]), .pt_wren(pt_wren[1])
  );

  logic [7:0] s_mem  [2][256];
  logic [7:0] ct_mem [2][256];
  logic [7:0] pt_mem [2][256];
  logic [7:0] s_stage  [256];
  logic [7:0] ct_stage [256];
  logic       load;

  logic [7:0] exp_pt     [2][256];
  bit         exp_wr     [2][256];
  logic [7:0] exp_s      [2][256];
  bit         exp_ok_run [2];
  int         exp_edges  [2];
  int         exp_swr    [2];
  int         exp_pwr    [2];

  bit         active      [2];
  bit         exp_idle_ok [2];
  int         cnt         [2];
  int         swr_cnt     [2];
  int         pwr_cnt     [2];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous-read RAMs with one-cycle latency; load copies the staging images.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      s_rddata[1'(d)]  <= s_mem[1'(d)][s_addr[1'(d)]];
      ct_rddata[1'(d)] <= ct_mem[1'(d)][ct_addr[1'(d)]];
      if (load) begin
        for (int x = 0; x < 256; x++) begin
          s_mem[1'(d)][8'(x)]  <= s_stage[8'(x)];
          ct_mem[1'(d)][8'(x)] <= ct_stage[8'(x)];
          pt_mem[1'(d)][8'(x)] <= FILL;
        end
      end else begin
        if (s_wren[1'(d)])  s_mem[1'(d)][s_addr[1'(d)]]   <= s_wrdata[1'(d)];
        if (pt_wren[1'(d)]) pt_mem[1'(d)][pt_addr[1'(d)]] <= pt_wrdata[1'(d)];
      end
    end
  end

  // Plain RC4 PRGA over the staged S for n bytes: keystream and final S.
  task automatic prga(input int n, output logic [7:0] ks [256], output logic [7:0] sf [256]);
    logic [7:0] s [256];
    logic [7:0] i, j, t, tmp;
    s = s_stage;
    i = 8'd0;
    j = 8'd0;
    for (int x = 0; x < 256; x++) ks[8'(x)] = 8'd0;
    for (int k = 1; k <= n; k++) begin
      i = i + 8'd1;
      j = j + s[i];
      tmp = s[i]; s[i] = s[j]; s[j] = tmp;
      t = s[i] + s[j];
      ks[8'(k)] = s[t];
    end
    sf = s;
  endtask

  task automatic build_model(input logic di, input bit chk_ascii);
    logic [7:0] ks [256];
    logic [7:0] sf [256];
    logic [7:0] len, p;
    int  n;
    bit  ok, stop;
    len = ct_stage[0];
    prga(int'(len), ks, sf);
    n = int'(len); ok = 1'b1; stop = 1'b0;
    for (int x = 0; x < 256; x++) begin
      exp_pt[di][8'(x)] = FILL;
      exp_wr[di][8'(x)] = 1'b0;
    end
    exp_pt[di][0] = len;
    exp_wr[di][0] = 1'b1;
    for (int k = 1; k <= int'(len); k++) begin
      if (!stop) begin
        p = ct_stage[8'(k)] ^ ks[8'(k)];
        exp_pt[di][8'(k)] = p;
        exp_wr[di][8'(k)] = 1'b1;
        if (p < 8'h20 || p > 8'h7E) begin
          ok = 1'b0;
          if (chk_ascii) begin stop = 1'b1; n = k; end
        end
      end
    end
    if (n != int'(len)) prga(n, ks, sf);
    for (int x = 0; x < 256; x++) exp_s[di][8'(x)] = sf[8'(x)];
    exp_ok_run[di] = ok;
    exp_edges[di]  = 4 + 6 * n;
    exp_swr[di]    = 2 * n;
    exp_pwr[di]    = n + 1;
  endtask

  task automatic end_of_run(input logic di);
    int bad_pt, bad_s, ip, is;
    bad_pt = -1; bad_s = -1;
    for (int x = 0; x < 256; x++) begin
      if (bad_pt < 0 && pt_mem[di][8'(x)] !== exp_pt[di][8'(x)]) bad_pt = x;
      if (bad_s < 0 && s_mem[di][8'(x)] !== exp_s[di][8'(x)]) bad_s = x;
    end
    ip = (bad_pt < 0) ? 0 : bad_pt;
    is = (bad_s < 0) ? 0 : bad_s;
    chk("pt_mem", {24'(ip), pt_mem[di][8'(ip)]}, {24'(ip), exp_pt[di][8'(ip)]});
    chk("s_mem", {24'(is), s_mem[di][8'(is)]}, {24'(is), exp_s[di][8'(is)]});
    chk("run_pt_ok", 32'(pt_ok[di]), 32'(exp_ok_run[di]));
    chk("s_write_count", 32'(swr_cnt[di]), 32'(exp_swr[di]));
    chk("pt_write_count", 32'(pwr_cnt[di]), 32'(exp_pwr[di]));
  endtask

  task automatic cmp(input logic di);
    if (!rst_n) begin
      active[di] = 1'b0;
      exp_idle_ok[di] = 1'b0;
      chk("reset_rdy", 32'(rdy[di]), 32'd1);
      chk("reset_pt_ok", 32'(pt_ok[di]), 32'd0);
      chk("reset_wren", 32'({s_wren[di], pt_wren[di]}), 32'd0);
    end else begin
      if (!active[di] && en[di]) begin
        active[di] = 1'b1;
        cnt[di] = 0; swr_cnt[di] = 0; pwr_cnt[di] = 0;
      end
      if (active[di]) begin
        cnt[di]++;
        chk("busy_rdy", 32'(rdy[di]), (cnt[di] >= exp_edges[di]) ? 32'd1 : 32'd0);
        if (s_wren[di]) swr_cnt[di]++;
        if (pt_wren[di]) begin
          pwr_cnt[di]++;
          chk("pt_write_addr", 32'(exp_wr[di][pt_addr[di]]), 32'd1);
          chk("pt_write_data", 32'(pt_wrdata[di]), 32'(exp_pt[di][pt_addr[di]]));
        end
        if (cnt[di] >= exp_edges[di]) begin
          end_of_run(di);
          exp_idle_ok[di] = exp_ok_run[di];
          active[di] = 1'b0;
        end
      end else begin
        chk("idle_rdy", 32'(rdy[di]), 32'd1);
        chk("idle_pt_ok", 32'(pt_ok[di]), 32'(exp_idle_ok[di]));
        chk("idle_wren", 32'({s_wren[di], pt_wren[di]}), 32'd0);
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) cmp(1'(d));
  end

  task automatic ksa_key();
    logic [7:0] key [3];
    logic [7:0] j, tmp;
    key[0] = 8'h4B; key[1] = 8'h65; key[2] = 8'h79;
    for (int x = 0; x < 256; x++) s_stage[8'(x)] = 8'(x);
    j = 8'd0;
    for (int x = 0; x < 256; x++) begin
      j = j + s_stage[8'(x)] + key[x % 3];
      tmp = s_stage[8'(x)]; s_stage[8'(x)] = s_stage[j]; s_stage[j] = tmp;
    end
  endtask

  task automatic set_rfc_ct();
    logic [7:0] ct [10];
    ct = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    for (int x = 0; x < 256; x++) ct_stage[8'(x)] = 8'd0;
    for (int x = 0; x < 10; x++) ct_stage[8'(x)] = ct[x];
  endtask

  task automatic load_mems();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
    build_model(1'b0, 1'b1);
    build_model(1'b1, 1'b0);
  endtask

  // Pulses en on both DUTs and returns the edge count at which each rdy rose.
  task automatic run(input int budget, input int busy_at, output int lat0, output int lat1);
    lat0 = 0; lat1 = 0;
    @(negedge clk); en[0] = 1'b1; en[1] = 1'b1;
    for (int n = 1; n <= budget; n++) begin
      if (lat0 == 0 || lat1 == 0) begin
        @(posedge clk); #2;
        if (n == 1 || n == busy_at + 1) begin en[0] = 1'b0; en[1] = 1'b0; end
        if (busy_at > 0 && n == busy_at) begin en[0] = 1'b1; en[1] = 1'b1; end
        if (lat0 == 0 && rdy[0] === 1'b1) lat0 = n;
        if (lat1 == 0 && rdy[1] === 1'b1) lat1 = n;
      end
    end
    chk("run_finished_chk", 32'(lat0 != 0), 32'd1);
    chk("run_finished_all", 32'(lat1 != 0), 32'd1);
    @(negedge clk);
  endtask

  task automatic printable_message(input int len, input int bad_pos);
    logic [7:0] ks [256];
    logic [7:0] sf [256];
    logic [7:0] p;
    prga(len, ks, sf);
    for (int x = 0; x < 256; x++) ct_stage[8'(x)] = 8'($urandom);
    ct_stage[0] = 8'(len);
    for (int k = 1; k <= len; k++) begin
      p = (k == bad_pos) ? 8'($urandom_range(31, 0)) : 8'($urandom_range(126, 32));
      ct_stage[8'(k)] = p ^ ks[8'(k)];
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat0, lat1, len, bad;
    logic [7:0] rfc_pt [9];
    logic [7:0] tmp;
    rfc_pt = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    rst_n = 1'b0; en[0] = 1'b0; en[1] = 1'b0; load = 1'b0;
    for (int d = 0; d < 2; d++) begin
      active[1'(d)] = 1'b0; exp_idle_ok[1'(d)] = 1'b0; exp_edges[1'(d)] = 4;
    end
    repeat (3) @(posedge clk);
    #3;
    for (int d = 0; d < 2; d++) begin
      chk("rst_rdy", 32'(rdy[1'(d)]), 32'd1);
      chk("rst_pt_ok", 32'(pt_ok[1'(d)]), 32'd0);
      chk("rst_addrs", {8'd0, s_addr[1'(d)], ct_addr[1'(d)], pt_addr[1'(d)]}, 32'd0);
      chk("rst_wdata", {16'd0, s_wrdata[1'(d)], pt_wrdata[1'(d)]}, 32'd0);
      chk("rst_wren", 32'({s_wren[1'(d)], pt_wren[1'(d)]}), 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;

    // RFC vector, key "Key"
    ksa_key(); set_rfc_ct(); load_mems();
    for (int k = 0; k < 9; k++) chk("model_rfc_pt", 32'(exp_pt[0][8'(k + 1)]), 32'(rfc_pt[k]));
    chk("model_rfc_edges", 32'(exp_edges[0]), 32'd58);
    run(200, 0, lat0, lat1);
    chk("rfc_latency_chk", 32'(lat0), 32'd58);
    chk("rfc_latency_all", 32'(lat1), 32'd58);
    chk("rfc_pt9", 32'(pt_mem[0][9]), 32'h74);
    chk("rfc_pt_ok", 32'(pt_ok[0]), 32'd1);

    // First plaintext byte becomes 0xD0
    ct_stage[1] = 8'h3B; load_mems();
    chk("model_bad_edges", 32'(exp_edges[0]), 32'd10);
    run(200, 0, lat0, lat1);
    chk("bad_latency_chk", 32'(lat0), 32'd10);
    chk("bad_latency_all", 32'(lat1), 32'd58);
    chk("bad_pt1", 32'(pt_mem[0][1]), 32'hD0);
    chk("bad_pt2_untouched", 32'(pt_mem[0][2]), 32'(FILL));
    chk("bad_pt_ok_chk", 32'(pt_ok[0]), 32'd0);
    chk("bad_pt_ok_all", 32'(pt_ok[1]), 32'd0);

    // Empty message
    ct_stage[0] = 8'h00; load_mems();
    run(50, 0, lat0, lat1);
    chk("len0_latency", 32'(lat0), 32'd4);
    chk("len0_pt0", 32'(pt_mem[1][0]), 32'd0);
    chk("len0_pt_ok", 32'(pt_ok[1]), 32'd1);

    // Identity S, L=255, printable text, en pulsed while busy
    for (int x = 0; x < 256; x++) s_stage[8'(x)] = 8'(x);
    printable_message(255, 0); load_mems();
    run(2000, 300, lat0, lat1);
    chk("ident_latency", 32'(lat0), 32'd1534);
    chk("ident_pt_ok", 32'(pt_ok[0]), 32'd1);

    // Reset in the middle of byte 3 of the RFC run
    ksa_key(); set_rfc_ct(); load_mems();
    @(negedge clk); en[0] = 1'b1; en[1] = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      @(posedge clk); #2;
      if (n == 1) begin en[0] = 1'b0; en[1] = 1'b0; end
    end
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("midrst_rdy", 32'(rdy[1'(d)]), 32'd1);
      chk("midrst_pt_ok", 32'(pt_ok[1'(d)]), 32'd0);
      chk("midrst_wren", 32'({s_wren[1'(d)], pt_wren[1'(d)]}), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    load_mems();
    run(200, 0, lat0, lat1);
    chk("rerun_latency", 32'(lat0), 32'd58);
    chk("rerun_pt1", 32'(pt_mem[0][1]), 32'h50);

    // Random permutations and messages, some with an injected bad byte
    for (int r = 0; r < 8; r++) begin
      for (int x = 255; x > 0; x--) begin
        int y;
        y = int'($urandom_range(x, 0));
        tmp = s_stage[8'(x)]; s_stage[8'(x)] = s_stage[8'(y)]; s_stage[8'(y)] = tmp;
      end
      len = int'($urandom_range(40, 0));
      bad = (len > 0 && $urandom_range(1, 0) == 1) ? int'($urandom_range(len, 1)) : 0;
      printable_message(len, bad);
      load_mems();
      run(400, 0, lat0, lat1);
      chk("rand_latency_chk", 32'(lat0), 32'(exp_edges[0]));
      chk("rand_latency_all", 32'(lat1), 32'(exp_edges[1]));
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
